// File: rtl/alu_pkg.sv
// Shared ALU/decode definitions: op codes, instruction field constants and the ID/EX bundle.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_SLT = 3'b100,
        ALU_DIV = 3'b101,
        ALU_NOP = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;

    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_DIV = 6'h1A;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        alu_op_t           op;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              illegal;
    } id_ex_bundle_t;

    // Undecodable encodings yield a NOP bundle with zero operands and ILLEGAL set.
    function automatic id_ex_bundle_t decode_instr(
        input logic [5:0]        opcode,
        input logic [5:0]        funct,
        input logic [REG_AW-1:0] rt,
        input logic [REG_AW-1:0] rd,
        input logic [15:0]       imm,
        input logic [DATA_W-1:0] rs_val,
        input logic [DATA_W-1:0] rt_val
    );
        id_ex_bundle_t b;
        b         = '0;
        b.op      = ALU_NOP;
        b.illegal = 1'b1;
        case (opcode)
            OPC_RTYPE: begin
                b.illegal   = 1'b0;
                b.op1       = rs_val;
                b.op2       = rt_val;
                b.dest      = rd;
                b.reg_write = 1'b1;
                case (funct)
                    FN_AND: b.op = ALU_AND;
                    FN_OR:  b.op = ALU_OR;
                    FN_ADD: b.op = ALU_ADD;
                    FN_SUB: b.op = ALU_SUB;
                    FN_SLT: b.op = ALU_SLT;
                    FN_DIV: b.op = ALU_DIV;
                    FN_MUL: b.op = ALU_MUL;
                    FN_NOP: begin
                        b.op        = ALU_NOP;
                        b.reg_write = 1'b0;
                    end
                    default: begin
                        b         = '0;
                        b.op      = ALU_NOP;
                        b.illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: begin
                b.illegal   = 1'b0;
                b.op1       = rs_val;
                b.dest      = rt;
                b.reg_write = 1'b1;
                case (opcode)
                    OPC_ADDI: begin b.op = ALU_ADD; b.op2 = {{(DATA_W-16){imm[15]}}, imm}; end
                    OPC_SLTI: begin b.op = ALU_SLT; b.op2 = {{(DATA_W-16){imm[15]}}, imm}; end
                    OPC_ANDI: begin b.op = ALU_AND; b.op2 = DATA_W'(imm); end
                    default:  begin b.op = ALU_OR;  b.op2 = DATA_W'(imm); end
                endcase
            end
            default: ;
        endcase
        if (b.dest == '0) b.reg_write = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Instruction-in / bundle-out handshake plus writeback port of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned REG_AW = alu_pkg::REG_AW
);
    logic [31:0]       INSTR;
    logic              IN_VALID;
    logic              IN_READY;
    logic              WB_WE;
    logic [REG_AW-1:0] WB_WA;
    logic [DATA_W-1:0] WB_WD;
    logic              FLUSH;
    logic              OUT_READY;
    logic              OUT_VALID;
    logic [DATA_W-1:0] OP1;
    logic [DATA_W-1:0] OP2;
    logic [2:0]        OP;
    logic [REG_AW-1:0] DEST;
    logic              REG_WRITE;
    logic              ILLEGAL;

    modport master (
        output INSTR, IN_VALID, WB_WE, WB_WA, WB_WD, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, OP1, OP2, OP, DEST, REG_WRITE, ILLEGAL
    );

    modport slave (
        input  INSTR, IN_VALID, WB_WE, WB_WA, WB_WD, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, OP1, OP2, OP, DEST, REG_WRITE, ILLEGAL
    );
endinterface

// File: rtl/reg_file.sv
// 2R/1W register file, R0 hardwired to zero, async clear.
// REGFILE_BYPASS_EN: same-cycle writes forward into the read ports.
module reg_file #(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned REG_AW = alu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we && (wa != '0)) mem_d[wa] = wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '{default: '0};
        else     mem_q <= mem_d;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] ra);
        logic [DATA_W-1:0] v;
        v = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == ra)) v = wd;
`endif
        if (ra == '0) v = '0;
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end
endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand stage feeding the ALU through a valid/ready ID/EX register.
// Optional macro REGFILE_BYPASS_EN enables register-file write-through.
module id_ex_stage #(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned REG_AW = alu_pkg::REG_AW
) (
    input logic          CLK,
    input logic          RST,
    id_ex_stage_if.slave bus
);
    import alu_pkg::*;

    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              unused_shamt;

    assign rs           = bus.INSTR[25:21];
    assign rt           = bus.INSTR[20:16];
    assign unused_shamt = ^bus.INSTR[10:6];

    reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_reg_file (
        .clk (CLK),
        .rst (RST),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rs_val),
        .rd2 (rt_val),
        .we  (bus.WB_WE),
        .wa  (bus.WB_WA),
        .wd  (bus.WB_WD)
    );

    id_ex_bundle_t bundle_q, bundle_d, dec_c;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_c;
    logic          xfer_c;

    // Flush wins over capture; a stalled bundle holds every field.
    always_comb begin
        in_ready_c  = !RST && (!out_valid_q || bus.OUT_READY);
        xfer_c      = bus.IN_VALID && in_ready_c && !bus.FLUSH;
        dec_c       = decode_instr(bus.INSTR[31:26], bus.INSTR[5:0], rt, bus.INSTR[15:11],
                                   bus.INSTR[15:0], rs_val, rt_val);
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (bus.FLUSH) begin
            out_valid_d        = 1'b0;
            bundle_d.reg_write = 1'b0;
        end else if (xfer_c) begin
            out_valid_d = 1'b1;
            bundle_d    = dec_c;
        end else if (bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.IN_READY  = in_ready_c;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OP1       = bundle_q.op1;
    assign bus.OP2       = bundle_q.op2;
    assign bus.OP        = bundle_q.op;
    assign bus.DEST      = bundle_q.dest;
    assign bus.REG_WRITE = bundle_q.reg_write;
    assign bus.ILLEGAL   = bundle_q.illegal;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage directly upstream of the ALU.
- Decodes a 32-bit MIPS-subset instruction and reads two operands from an internal 32x32 register file.
- Produces the ALU's 3-bit OP code and 32-bit OP1/OP2 operands, registered in an ID/EX pipeline register with a valid/ready handshake.
- Accepts the writeback port from the downstream stage.

Parameters:
- DATA_W, 32, operand/register width.
- REG_AW, 5, register address width (2^REG_AW registers).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- INSTR  in  32  instruction word.
- IN_VALID  in  1  INSTR valid.
- IN_READY  out  1  stage can accept INSTR this cycle.
- WB_WE  in  1  register-file write enable.
- WB_WA  in  REG_AW  write address.
- WB_WD  in  DATA_W  write data.
- FLUSH  in  1  discard the pipeline-register content.
- OUT_READY  in  1  ALU side accepts the output.
- OUT_VALID  out  1  output bundle valid.
- OP1  out  DATA_W  ALU operand 1.
- OP2  out  DATA_W  ALU operand 2.
- OP  out  3  ALU op code.
- DEST  out  REG_AW  destination register.
- REG_WRITE  out  1  result is to be written back.
- ILLEGAL  out  1  bundle came from an undecodable instruction.

Behaviour:
- Reset (async, active-high): all outputs are 0; every register-file entry is 0.
- ALU OP encoding:
  - AND=000, OR=001, ADD=010, SUB=011, SLT=100, DIV=101, NOP=110, MUL=111.
- R-type (opcode 000000):
  - OP1 = R[rs], OP2 = R[rt], DEST = rd.
  - funct map: 0x24 AND, 0x25 OR, 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x1A DIV, 0x18 MUL.
  - 0x00 gives NOP with REG_WRITE=0.
- I-type: OP1 = R[rs], DEST = rt.
  - ADDI 0x08 → ADD, sign-extended imm.
  - SLTI 0x0A → SLT, sign-extended imm.
  - ANDI 0x0C → AND, zero-extended imm.
  - ORI 0x0D → OR, zero-extended imm.
- Any other opcode or funct: OP=NOP, REG_WRITE=0, ILLEGAL=1, operands 0.
- REG_WRITE is forced to 0 whenever DEST==0.
- Register 0 always reads 0; writes to address 0 are ignored.
- Register-file write occurs on the rising edge when WB_WE=1.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - A transfer occurs when IN_VALID && IN_READY; the bundle is captured next edge and OUT_VALID=1 (latency 1 cycle).
  - With OUT_VALID && !OUT_READY (stall), all outputs hold stable.
  - OUT_VALID clears when the output is accepted and no new transfer occurs.
- FLUSH has priority over everything:
  - Next edge gives OUT_VALID=0 and REG_WRITE=0.
  - Any simultaneous input transfer is dropped.
  - Register-file writes are still performed.
- Simultaneous write and read of the same register: see Optional Feature.
- Mid-operation RST: immediately returns to the reset state; the pending bundle is lost.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a same-cycle WB_WE write to a nonzero WB_WA equal to rs or rt forwards WB_WD into the captured operand (write-through).
- Undefined: the captured operand is the pre-write value; the downstream stage must avoid this hazard.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants (AND..MUL).
  - Opcode/funct constants.
  - DATA_W and REG_AW defaults.
  - The ID/EX bundle typedef (OP1, OP2, OP, DEST, REG_WRITE, ILLEGAL).
- Natural sub-module: reg_file.
  - Contents: 2 async read ports, 1 sync write port, R0 hardwired to 0, async reset clear.
  - The bypass lives in reg_file under the macro.

Test Plan:
- Reset then write R1=5, R2=3; issue ADD r3,r1,r2 (0x00221820), OUT_READY=1 → next cycle OUT_VALID=1, OP=010, OP1=5, OP2=3, DEST=3, REG_WRITE=1.
- ADDI r4,r1,-1 (0x2024FFFF) → OP2=0xFFFFFFFF, OP=010. ANDI r4,r1,0xFFFF (0x3024FFFF) → OP2=0x0000FFFF, OP=000.
- OUT_READY=0 with a bundle held, new INSTR presented → IN_READY=0, outputs unchanged for 3 cycles. Raising OUT_READY → next instruction captured on the following edge.
- FLUSH asserted with IN_VALID=1 → next cycle OUT_VALID=0. Write R0=0xDEAD → a later read of R0 gives 0.
- WB write R1=7 in the same cycle as SUB r5,r1,r2 (R2=3) → OP1=7 with REGFILE_BYPASS_EN, OP1=5 without.
- Opcode 0x3F, then funct 0x3F → ILLEGAL=1, OP=110, REG_WRITE=0. Assert RST mid-stall → all outputs 0 immediately, R1 reads 0.
